myproject_mac_acc_29s_16s: RTL
==============================

# myproject_mac_acc_29s_16s

Downstream consumer of the 16s×13s→29s product stage. Accumulates `N_TERMS` consecutive signed 29-bit products plus a per-output bias, then rounds, shifts and saturates the sum into a 16-bit signed fixed-point result. It closes one dense-layer neuron: multiplier outputs stream in, and one neuron activation value streams out per `N_TERMS` accepted products.

## Interface
Parameters:
- `N_TERMS`, 4: products per output; must be ≥1.
- `DIN_WIDTH`, 29: product width, signed.
- `ACC_WIDTH`, 36: accumulator width, signed; must be ≥ DIN_WIDTH+clog2(N_TERMS)+1.
- `BIAS_WIDTH`, 16: bias width, signed.
- `BIAS_LSH`, 10: left shift that aligns the bias to the product LSB.
- `SHIFT`, 10: right shift from accumulator to output LSB; must be ≥1.
- `DOUT_WIDTH`, 16: output width, signed.

Ports (one clock; reset is asynchronous and active-low):
- `ap_clk` in 1: clock, rising edge.
- `ap_rst_n` in 1: asynchronous active-low reset.
- `din` in DIN_WIDTH: product from the multiplier stage.
- `din_vld` in 1: `din` is valid.
- `din_rdy` out 1: block accepts `din` this cycle.
- `bias` in BIAS_WIDTH: sampled with the first term of each output.
- `dout` out DOUT_WIDTH: saturated result.
- `dout_sat` out 1: `dout` was clipped; qualified by `dout_vld`.
- `dout_vld` out 1: result valid.
- `dout_rdy` in 1: consumer accepts the result.

## Operation
- Accept: `acc_fire = din_vld & din_rdy`. Deliver: `out_fire = dout_vld & dout_rdy`.
- Term counter `cnt` counts 0..N_TERMS-1.
- On `acc_fire` with `cnt==0`: `acc <= sext(bias)<<<BIAS_LSH + sext(din)`.
- On `acc_fire` with `cnt>0`: `acc <= acc + sext(din)`.
- `cnt` increments on every `acc_fire` and wraps to 0 after N_TERMS-1.
- Final term (`acc_fire` with `cnt==N_TERMS-1`):
  - `sum = acc_next` (full ACC_WIDTH).
  - `r = (sum + 2^(SHIFT-1)) >>> SHIFT`. This is round-half-up (toward +∞) on ties, arithmetic shift, computed at ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - If `r > 2^(DOUT_WIDTH-1)-1`, then `dout = max` and `dout_sat = 1`.
  - If `r < -2^(DOUT_WIDTH-1)`, then `dout = min` and `dout_sat = 1`.
  - Otherwise `dout = r[DOUT_WIDTH-1:0]` and `dout_sat = 0`.
  - `dout_vld <= 1`.
- When N_TERMS=1, every accepted term produces an output.
- FSM:
  - ACC: `dout_vld = 0`, or the held result has been consumed.
  - HOLD: `dout_vld = 1` and not yet consumed.
  - ACC→HOLD on the final-term `acc_fire`.
  - HOLD→ACC on `out_fire` with no simultaneous final-term fire.
  - HOLD→HOLD when `out_fire` and a final-term fire coincide; the new result replaces the old one.
- `din_rdy = ~dout_vld | dout_rdy` (combinational). Non-final terms are also stalled in HOLD; the accumulator must not advance while an undelivered result is held.
- `dout` and `dout_sat` change only on the final-term fire and stay stable while `dout_vld & ~dout_rdy`.
- Accumulator overflow cannot occur when the ACC_WIDTH rule is met; no wrap detection is required.

## Timing
- Reset values (asynchronous assert, synchronous release to the next edge): `cnt=0`, `acc=0`, `dout=0`, `dout_sat=0`, `dout_vld=0`, FSM in ACC. `din_rdy` is 1 out of reset.
- Reset mid-accumulation discards the partial sum and any held result. The next accepted term is term 0 and samples the bias again.
- Latency: `dout_vld` rises 1 cycle after the final term's accepting edge.
- Throughput: one term per cycle with `dout_rdy` held high. Back-to-back outputs every N_TERMS cycles, with no bubbles.
- `din`, `bias` and `din_vld` are sampled only on rising edges with `acc_fire`. `din` is don't-care when `din_vld=0`.
- `dout_vld`, once high, stays high until `out_fire`. There is no retraction.

## Test plan
- Basic sum: defaults, bias=0, din=1024 ×4 with dout_rdy=1 → one result dout=4, dout_sat=0, dout_vld high exactly 1 cycle after the 4th term.
- Rounding and bias: bias=1, din={512,0,0,0} → sum 1536 → dout=2. Then bias=-2, din={512,0,0,0} → sum -1536 → dout=-1 (tie rounds toward +∞).
- Saturation: din=2^28-1 ×4, bias=32767 → dout=32767, dout_sat=1. Then din=-2^28 ×4, bias=-32768 → dout=-32768, dout_sat=1.
- Back-pressure: stream 12 terms of din=1024 with din_vld=1 continuously; hold dout_rdy=0 for 5 cycles after the first result.
  - Required: din_rdy=0 while the result is held; dout stays stable.
  - No term is lost; results are {4,4,4} in order.
  - Simultaneous deliver and final-accept keeps dout_vld high with the new value.
- Reset mid-operation: accept 2 terms of 1024, pulse ap_rst_n low asynchronously between edges, then send 4×1024 with bias=0 → dout_vld=0 during reset, single result dout=4 (partial sum discarded).
- Random: 1000 outputs with random din, bias, din_vld and dout_rdy, checked against a reference model of round-half-up, shift and saturate, plus an ordering scoreboard.

Source files
------------

// File: rtl/myproject_mac_acc_29s_16s.sv
// Multiply-accumulate closer for one dense-layer neuron: sums N_TERMS signed
// products plus a shifted bias, then rounds half-up, shifts and saturates.
module myproject_mac_acc_29s_16s #(
  parameter int N_TERMS    = 4,
  parameter int DIN_WIDTH  = 29,
  parameter int ACC_WIDTH  = 36,
  parameter int BIAS_WIDTH = 16,
  parameter int BIAS_LSH   = 10,
  parameter int SHIFT      = 10,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_sat,
  output logic                  dout_vld,
  input  logic                  dout_rdy
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  localparam logic signed [ACC_WIDTH:0] RND  = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] DMAX = {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] DMIN = {{(ACC_WIDTH-DOUT_WIDTH+2){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t                      state, state_n;
  logic [CW-1:0]               cnt;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, din_ext, bias_ext;
  logic signed [ACC_WIDTH:0]   sum_r, r;
  logic [DOUT_WIDTH-1:0]       res;
  logic                        res_sat;
  logic                        acc_fire, out_fire, last;

  assign dout_vld = (state == S_HOLD);
  assign din_rdy  = ~dout_vld | dout_rdy;
  assign acc_fire = din_vld & din_rdy;
  assign out_fire = dout_vld & dout_rdy;
  assign last     = (cnt == LAST);

  assign din_ext  = {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias} <<< BIAS_LSH;

  // Rounding add is done one bit wider than the accumulator so it cannot wrap.
  always_comb begin
    acc_next = (cnt == '0) ? (bias_ext + din_ext) : (acc + din_ext);
    sum_r    = {acc_next[ACC_WIDTH-1], acc_next} + RND;
    r        = sum_r >>> SHIFT;
    res      = r[DOUT_WIDTH-1:0];
    res_sat  = 1'b0;
    if (r > DMAX) begin
      res     = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      res_sat = 1'b1;
    end else if (r < DMIN) begin
      res     = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if (acc_fire && last) state_n = S_HOLD;
    else if (out_fire)    state_n = S_ACC;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_ACC;
    else           state <= state_n;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_sat <= 1'b0;
    end else if (acc_fire) begin
      acc <= acc_next;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        dout     <= res;
        dout_sat <= res_sat;
      end
    end
  end

endmodule
